psum_reader: RTL
================

# psum_reader

Drain engine on the read side of a PE's PSUM scratchpad. On `start` it walks a contiguous, wrap-around address range of the scratchpad and streams each signed partial sum out over a valid/ready interface, one entry per cycle at full throughput. It sits between the PSUM scratchpad's combinational read port and the PE's output bus toward the global buffer.

## Interface
- `ADDR_LEN`, 4: scratchpad address width.
- `SCRATCH_DEPTH`, 16: number of scratchpad entries; need not be a power of two.
- `SCRATCH_WIDTH`, 16: signed partial-sum width.
- `clk`  in  1  single clock, all logic on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  begin a drain; sampled only in IDLE.
- `base_addr`  in  ADDR_LEN  first address to read; sampled with `start`.
- `count`  in  ADDR_LEN+1  number of entries to read; sampled with `start`.
- `raddr`  out  ADDR_LEN  scratchpad read address.
- `psum_dout`  in  SCRATCH_WIDTH  signed scratchpad read data; combinational from `raddr`.
- `out_data`  out  SCRATCH_WIDTH  signed output beat.
- `out_valid`  out  1  `out_data` is valid.
- `out_last`  out  1  current beat is the final beat of the drain.
- `out_ready`  in  1  consumer accepts the beat.
- `busy`  out  1  drain in progress.
- `done`  out  1  one-cycle pulse when a drain completes.

## Operation
- FSM states are IDLE, READ, and DRAIN.
- IDLE:
  - `start` with effective count 0 goes to IDLE and pulses `done` next cycle. No beats are sent.
  - `start` with effective count >0 loads `raddr<=base_addr` and `remaining<=count`, then goes to READ.
  - Effective count is `min(count, SCRATCH_DEPTH)`.
- READ:
  - The load condition is `!out_valid || out_ready`.
  - On load:
    - `out_data<=f(psum_dout)`, `out_valid<=1`.
    - `out_last<=(remaining==1)`.
    - Decrement `remaining`.
    - Advance `raddr`, wrapping `SCRATCH_DEPTH-1 -> 0`.
  - After loading the last entry, go to DRAIN.
- DRAIN:
  - Hold until `out_valid && out_ready`, then clear `out_valid` and go to IDLE.
  - Assert `done` for one cycle and deassert `busy`.
- Handshake:
  - A beat transfers on any cycle with `out_valid && out_ready`.
  - While `out_valid && !out_ready`, `out_data`, `out_last` and `raddr` hold stable.
  - `out_valid` never drops without a transfer.
- `start` while `busy` is ignored.
- `f(x)=x` by default; see Configuration.
- Data is passed through bit-exact with no width change.
- Mid-drain `rst`: all state returns to reset values and no further beats are sent. `done` is not pulsed.
- The upstream controller guarantees no scratchpad writes to addresses inside an active drain range. This block does not check it.

## Timing
- Reset values: `raddr=0`, `out_data=0`, `out_valid=0`, `out_last=0`, `busy=0`, `done=0`, state IDLE.
- `start` sampled at edge T gives `busy=1` and `raddr=base_addr` after T.
- The first beat has `out_valid=1` after T+1.
- With `out_ready` held high, beats issue on consecutive cycles. Beat k is valid after edge T+1+k.
- The final transfer at edge H is followed by `done=1` and `busy=0` after H, in IDLE.
- A new `start` is accepted at the edge after H at the earliest.
- Count 0: `done=1` after T; `busy` never asserts.

## Configuration
- `PSUM_RELU_EN`:
  - Defined: `f(x) = (x<0) ? 0 : x`, applied when a beat is loaded into the output register. Latency and handshake are unchanged.
  - Undefined: `f(x)=x` and no comparator is built.

## Structure
- The shared package holds:
  - the FSM state enum (IDLE, READ, DRAIN);
  - a `psum_wrap_inc` address-increment function parameterised by depth.
- One sub-module: `stream_out_reg`, a single-entry valid/ready output register carrying data+last.
  - It exposes `load_en = !out_valid || out_ready`.
  - It is reusable for the IF and filter fill paths.
- The FSM, counter and address generator stay in `psum_reader`.

## Test plan
- Basic drain:
  - Preload entries 0..3 with 5, -7, 12, 0.
  - Drive `start`, `base_addr=0`, `count=4`, `out_ready=1`.
  - Expect 4 consecutive beats 5, -7, 12, 0, `out_last` on the 4th, and `done` one cycle after.
- Wrap-around:
  - Use `SCRATCH_DEPTH=16`, `base_addr=14`, `count=4`.
  - Expect `raddr` 14, 15, 0, 1 and data in that order.
- Backpressure:
  - Hold `out_ready=0` for 3 cycles after the first beat, then toggle it 1/0.
  - Expect `out_data` stable while stalled, no beat lost or duplicated, and 4 transfers total.
- Boundaries:
  - `count=0` gives `done` next cycle, no `out_valid`, `busy=0`.
  - `count=20` clamps to 16 beats.
  - `start` pulsed mid-drain is ignored.
- Reset mid-drain:
  - Assert `rst` after beat 2 of 8.
  - Expect all outputs 0 next cycle and no `done`.
  - A fresh `start` afterwards drains correctly.
- `PSUM_RELU_EN`:
  - Stream -3, 9, -32768, 0.
  - Expect 0, 9, 0, 0 with identical timing to the non-ReLU build.

Source files
------------

// File: rtl/psum_reader_pkg.sv
// psum_reader_pkg
//   Shared types and helpers for the PSUM drain engine.
//   - psum_state_e  : drain FSM states (IDLE, READ, DRAIN)
//   - psum_wrap_inc : address increment that wraps at an arbitrary depth
package psum_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } psum_state_e;

    // Depth need not be a power of two, so the wrap is an explicit compare
    // rather than relying on natural address overflow.
    function automatic logic [31:0] psum_wrap_inc(input logic [31:0] addr,
                                                  input int unsigned depth);
        return (addr >= depth - 32'd1) ? 32'd0 : addr + 32'd1;
    endfunction

endpackage

// File: rtl/psum_reader_if.sv
// psum_reader_if
//   Valid/ready output stream carrying signed partial sums toward the
//   global buffer.
//   out_data  : signed beat data (WIDTH bits)
//   out_valid : beat valid
//   out_last  : final beat of a drain
//   out_ready : consumer accepts the beat
//   master drives data/valid/last, slave drives ready.
interface psum_reader_if #(
    parameter int WIDTH = 16
);
    logic signed [WIDTH-1:0] out_data;
    logic                    out_valid;
    logic                    out_last;
    logic                    out_ready;

    modport master (output out_data, output out_valid, output out_last, input out_ready);
    modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/stream_out_reg.sv
// stream_out_reg
//   Single-entry valid/ready output register carrying data + last.
//   Ports:
//     clk, rst   : clock, synchronous active-high reset
//     load       : producer wants to push in_data/in_last this cycle
//     in_data    : data to register
//     in_last    : last flag to register
//     load_en    : register can accept a new entry (!out_valid || out_ready)
//     out_data   : registered data, stable while stalled
//     out_valid  : registered entry valid
//     out_last   : registered last flag
//     out_ready  : consumer accepts the current entry
//   A push is taken only when load && load_en; the caller gates its own
//   side effects (address/counter advance) on the same load_en.
module stream_out_reg #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             load_en,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             out_last,
    input  logic             out_ready
);
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;

    assign load_en = !valid_q || out_ready;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        if (load && load_en) begin
            data_d  = in_data;
            last_d  = in_last;
            valid_d = 1'b1;
        end else if (valid_q && out_ready) begin
            // Transfer with nothing behind it: empty the slot, keep data.
            valid_d = 1'b0;
            last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign out_last  = last_q;

endmodule

// File: rtl/psum_reader.sv
// psum_reader
//   Drain engine for a PE's PSUM scratchpad. On start, walks a contiguous
//   wrap-around address range and streams each entry out at one beat per
//   cycle over a valid/ready interface.
//   Ports:
//     clk, rst   : clock, synchronous active-high reset
//     start      : begin a drain (sampled only when idle)
//     base_addr  : first address, sampled with start
//     count      : entries to read (clamped to SCRATCH_DEPTH), sampled with start
//     raddr      : scratchpad read address
//     psum_dout  : combinational scratchpad read data for raddr
//     out_if     : output stream (data/valid/last/ready)
//     busy       : drain in progress
//     done       : one-cycle pulse when a drain completes
//   Build option: define PSUM_RELU_EN to clamp negative partial sums to zero
//   as they enter the output register.
module psum_reader
    import psum_reader_pkg::*;
#(
    parameter int ADDR_LEN      = 4,
    parameter int SCRATCH_DEPTH = 16,
    parameter int SCRATCH_WIDTH = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [ADDR_LEN-1:0]             base_addr,
    input  logic [ADDR_LEN:0]               count,
    output logic [ADDR_LEN-1:0]             raddr,
    input  logic signed [SCRATCH_WIDTH-1:0] psum_dout,
    psum_reader_if.master                   out_if,
    output logic                            busy,
    output logic                            done
);
    localparam logic [ADDR_LEN:0] DEPTH_C = (ADDR_LEN+1)'(SCRATCH_DEPTH);

    psum_state_e          state_q, state_d;
    logic [ADDR_LEN-1:0]  raddr_q, raddr_d;
    logic [ADDR_LEN:0]    remaining_q, remaining_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic [ADDR_LEN:0]        cnt_eff;
    logic                     load;
    logic                     load_en;
    logic [SCRATCH_WIDTH-1:0] load_data;

    assign cnt_eff = (count > DEPTH_C) ? DEPTH_C : count;
    assign load    = (state_q == ST_READ);

    always_comb begin
`ifdef PSUM_RELU_EN
        load_data = psum_dout[SCRATCH_WIDTH-1] ? '0 : psum_dout;
`else
        load_data = psum_dout;
`endif
    end

    always_comb begin
        state_d     = state_q;
        raddr_d     = raddr_q;
        remaining_d = remaining_q;
        done_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (cnt_eff == '0) begin
                        done_d = 1'b1;
                    end else begin
                        raddr_d     = base_addr;
                        remaining_d = cnt_eff;
                        state_d     = ST_READ;
                    end
                end
            end
            ST_READ: begin
                // Address and counter advance only when the output register
                // actually takes the entry, so raddr holds during a stall.
                if (load_en) begin
                    remaining_d = remaining_q - 1'b1;
                    raddr_d     = ADDR_LEN'(psum_wrap_inc(32'(raddr_q),
                                                          unsigned'(SCRATCH_DEPTH)));
                    if (remaining_q == 1) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (out_if.out_valid && out_if.out_ready) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            raddr_q     <= '0;
            remaining_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            raddr_q     <= raddr_d;
            remaining_q <= remaining_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    stream_out_reg #(.WIDTH(SCRATCH_WIDTH)) u_out (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .in_data   (load_data),
        .in_last   (remaining_q == 1),
        .load_en   (load_en),
        .out_data  (out_if.out_data),
        .out_valid (out_if.out_valid),
        .out_last  (out_if.out_last),
        .out_ready (out_if.out_ready)
    );

    assign raddr = raddr_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule
